md_scheduler: RTL and testbench

// Sequences the shared multiply/divide resource for the E stage of the pipelined CPU.

---
 rtl/md_scheduler.sv | 122 ++++++++++++
 tb/tb_md_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the E stage: fixed-latency busy window, owns HI/LO.
// Optional MD_MADD_EN macro adds madd/maddu/msub/msubu (mdop 6-9) accumulating into HI/LO.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    input  logic        md_d,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        state_dbg
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {CM_NONE, CM_LOAD, CM_ADD, CM_SUB} commit_t;

    // Handshake: start is a one-cycle strobe; it is accepted (start_ok) only in IDLE
    // without a same-cycle flush, and md_stall holds D while the unit is or becomes busy.
    state_t        state;
    commit_t       cmode;
    logic [CW-1:0] cnt;
    logic [63:0]   res;

    logic          start_ok;
    logic          sgn;
    logic [63:0]   a64, b64, prod;
    logic signed [32:0] a33, b33;
    logic [31:0]   quot, rem;

    assign start_ok  = start & ~flush & (state == IDLE);
    assign md_stall  = md_d & (busy | start_ok);
    assign state_dbg = (state == RUN);

    // Even codes are the signed variants across mult, div and the accumulate ops.
    assign sgn  = ~mdop[0];
    assign a64  = sgn ? {{32{src1[31]}}, src1} : {32'd0, src1};
    assign b64  = sgn ? {{32{src2[31]}}, src2} : {32'd0, src2};
    assign prod = a64 * b64;

    // 33-bit operands keep 0x80000000 / -1 representable before truncation.
    assign a33  = {sgn & src1[31], src1};
    assign b33  = {sgn & src2[31], src2};
    assign quot = 32'(a33 / b33);
    assign rem  = 32'(a33 % b33);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cmode <= CM_NONE;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        case (mdop)
                            4'd0, 4'd1: begin
                                res   <= prod;
                                cmode <= CM_LOAD;
                                cnt   <= MULT_LOAD;
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            4'd2, 4'd3: begin
                                res   <= {rem, quot};
                                cmode <= (src2 == 32'd0) ? CM_NONE : CM_LOAD;
                                cnt   <= DIV_LOAD;
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            4'd4: hi <= src1;
                            4'd5: lo <= src1;
`ifdef MD_MADD_EN
                            4'd6, 4'd7, 4'd8, 4'd9: begin
                                res   <= prod;
                                cmode <= (mdop[3]) ? CM_SUB : CM_ADD;
                                cnt   <= MULT_LOAD;
                                busy  <= 1'b1;
                                state <= RUN;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        // Accumulate ops read HI/LO here, at commit, not at issue.
                        case (cmode)
                            CM_LOAD: {hi, lo} <= res;
                            CM_ADD:  {hi, lo} <= {hi, lo} + res;
                            CM_SUB:  {hi, lo} <= {hi, lo} - res;
                            default: ;
                        endcase
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: driver pushes expected {busy cycles, hi, lo},
// monitor pops on busy falling or on a driver check request.
module tb_md_scheduler;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] src1, src2;
    logic        flush;
    logic        md_d;
    logic        busy, md_stall, state_dbg;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    logic [71:0] exp_q[$];
    logic [31:0] m_hi, m_lo;
    logic        chk_req = 1'b0;
    logic        mon_en  = 1'b0;
    logic        busy_q  = 1'b0;
    int          busy_cnt = 0;

    md_scheduler #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop), .src1(src1), .src2(src2),
        .flush(flush), .md_d(md_d), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // md_d toggles randomly, away from both edges
    initial begin
        md_d = 1'b0;
        @(posedge reset);
        forever begin
            @(posedge clk);
            #2 md_d = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // reference model: applies an op to m_hi/m_lo and returns busy length
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic fl, output int cyc);
        longint      sp, sq, sr;
        logic [63:0] up;
        cyc = 0;
        if (fl) return;
        case (op)
            4'd0: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                {m_hi, m_lo} = sp;
                cyc = MULT_CYCLES;
            end
            4'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = up;
                cyc = MULT_CYCLES;
            end
            4'd2: begin
                if (b != 0) begin
                    sq = longint'(int'(a)) / longint'(int'(b));
                    sr = longint'(int'(a)) % longint'(int'(b));
                    m_lo = sq[31:0];
                    m_hi = sr[31:0];
                end
                cyc = DIV_CYCLES;
            end
            4'd3: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                cyc = DIV_CYCLES;
            end
            4'd4: m_hi = a;
            4'd5: m_lo = a;
`ifdef MD_MADD_EN
            4'd6, 4'd8: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                up = (op == 4'd6) ? ({m_hi, m_lo} + 64'(sp)) : ({m_hi, m_lo} - 64'(sp));
                {m_hi, m_lo} = up;
                cyc = MULT_CYCLES;
            end
            4'd7, 4'd9: begin
                up = {32'd0, a} * {32'd0, b};
                up = (op == 4'd7) ? ({m_hi, m_lo} + up) : ({m_hi, m_lo} - up);
                {m_hi, m_lo} = up;
                cyc = MULT_CYCLES;
            end
`endif
            default: ;
        endcase
    endtask

    // driver: issue one op, push expectation, wait for completion
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        int cyc;
        int n;
        logic [7:0] c8;
        model_op(op, a, b, fl, cyc);
        c8 = 8'(cyc);
        @(posedge clk);
        #1;
        start = 1'b1; mdop = op; src1 = a; src2 = b; flush = fl;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        src1 = $urandom; src2 = $urandom;
        exp_q.push_back({c8, m_hi, m_lo});
        if (cyc == 0) begin
            chk_req = 1'b1;
            @(posedge clk);
            #1 chk_req = 1'b0;
        end else begin
            // a start while running must be ignored
            if (cyc > 2 && $urandom_range(0, 1) == 1) begin
                start = 1'b1; mdop = 4'd5; src1 = $urandom;
                @(posedge clk);
                #1 start = 1'b0;
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (busy && n < 40);
            if (busy) begin
                checks++;
                failures++;
                $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, n);
            end
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [71:0] e;
        logic        exp_stall;
        if (!mon_en) begin
            busy_cnt = 0;
        end else begin
            exp_stall = md_d & (busy | (start & ~flush & ~busy));
            check("md_stall", {31'd0, md_stall}, {31'd0, exp_stall});
            if (busy) busy_cnt++;
            if ((busy_q && !busy) || chk_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_empty: completion seen, required an expected entry");
                end else begin
                    e = exp_q.pop_front();
                    check("hi", hi, e[63:32]);
                    check("lo", lo, e[31:0]);
                    check("busy_cycles", 32'(busy_cnt), {24'd0, e[71:64]});
                end
                busy_cnt = 0;
            end
        end
        busy_q = busy;
    end

    initial begin
        int n;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        fl;
        reset = 1'b1; start = 1'b0; mdop = 4'd0; src1 = '0; src2 = '0; flush = 1'b0;
        m_hi = '0; m_lo = '0;
        #1 reset = 1'b0;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", {31'd0, md_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        // directed cases
        do_op(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        do_op(4'd3, 32'd100, 32'd7, 1'b0);
        do_op(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(4'd2, 32'd55, 32'd0, 1'b0);
        do_op(4'd0, 32'd9, 32'd9, 1'b1);
        do_op(4'd5, 32'h0000_1234, 32'd0, 1'b0);
        do_op(4'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(4'd12, 32'h1111_1111, 32'd2, 1'b0);
        do_op(4'd4, 32'd0, 32'd0, 1'b0);
        do_op(4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(4'd6, 32'd1, 32'd1, 1'b0);
        do_op(4'd8, 32'd3, 32'd5, 1'b0);
        do_op(4'd9, 32'hFFFF_FFFF, 32'd2, 1'b0);

        // randomized ops
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            fl = ($urandom_range(0, 7) == 0);
            do_op(op, a, b, fl);
        end

        // reset while running: busy/hi/lo clear without a clock edge
        do_op(4'd4, 32'hA5A5_0001, 32'd0, 1'b0);
        do_op(4'd5, 32'h5A5A_0002, 32'd0, 1'b0);
        @(posedge clk);
        mon_en = 1'b0;
        #1;
        start = 1'b1; mdop = 4'd3; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrun_reset_busy", {31'd0, busy}, 32'd0);
        check("midrun_reset_hi", hi, 32'd0);
        check("midrun_reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        do_op(4'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
